// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch stage.
//
// Owns the program counter and fetches one word at a time from instruction memory
// (valid/ready request, valid-only in-order response, at most one request outstanding).
// Fetched words are buffered in a 2-entry FIFO together with their PC and presented
// to decode with opcode/funct3 pre-extracted. A redirect from execute empties the
// FIFO, reloads the PC and causes any in-flight response to be discarded.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   imem_req_valid/ready, imem_addr  fetch request (word address)
//   imem_rsp_valid, imem_rsp_data    fetch response
//   redirect_valid, redirect_pc      control-flow redirect (pc[1:0] forced to 0)
//   id_valid/ready                   decode handshake on the FIFO head
//   id_instr, id_pc, id_pc_plus4     head instruction, its PC, PC + 4
//   id_opcode, id_funct3             instr[6:0], instr[14:12]
//   perf_fetched, perf_stall         only with FETCH_PERF_CNT_EN defined
//
// Configuration macro: FETCH_PERF_CNT_EN adds the push and decode-stall counters.
// Parameters: RESET_PC (reset program counter), FIFO_DEPTH (only 2 is supported).
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam logic [1:0] FullCount = 2'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StDrain
  } state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_req_pc;          // PC of the outstanding request
  logic [31:0] r_fifo_instr [2];
  logic [31:0] r_fifo_pc    [2];
  logic        r_rd_ptr, r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_handshake;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_redirect_target;
  logic        w_unused;

  assign w_redirect_target = {redirect_pc[31:2], 2'b00};
  assign w_unused          = ^redirect_pc[1:0];

  // In REQ nothing is in flight, so the issue rule reduces to FIFO room.
  assign imem_req_valid = ~rst & (r_state == StReq) & (r_count < FullCount);
  assign imem_addr      = r_pc;
  assign w_handshake    = imem_req_valid & imem_req_ready;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    w_pop        = id_valid & id_ready & ~redirect_valid;
    case (r_state)
      StReq: begin
        if (w_handshake) begin
          w_pc_next    = r_pc + 32'd4;
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          w_push       = ~redirect_valid;
          w_state_next = StReq;
        end
      end
      StDrain: begin
        if (imem_rsp_valid) w_state_next = StReq;
      end
      default: w_state_next = StReq;
    endcase

    // Redirect overrides everything decided above.
    if (redirect_valid) begin
      w_pc_next = w_redirect_target;
      case (r_state)
        StReq:           w_state_next = w_handshake ? StDrain : StReq;
        StWait, StDrain: w_state_next = imem_rsp_valid ? StReq : StDrain;
        default:         w_state_next = StReq;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StReq;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_handshake) r_req_pc <= r_pc;
    end
  end

  // Two-entry FIFO. When full, a push always comes with a pop, so writing the slot
  // under the write pointer (which then equals the read pointer) never loses data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
        r_fifo_pc[r_wr_ptr]    <= r_req_pc;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign id_valid    = (r_count != 2'd0);
  assign id_instr    = r_fifo_instr[r_rd_ptr];
  assign id_pc       = r_fifo_pc[r_rd_ptr];
  assign id_pc_plus4 = id_pc + 32'd4;
  assign id_opcode   = id_instr[6:0];
  assign id_funct3   = id_instr[14:12];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_push) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (id_ready & ~id_valid) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model, a randomised instruction memory,
// per-cycle output comparison and a few hand-computed directed checks.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_opcode      (id_opcode),
    .id_funct3      (id_funct3)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: expected PC, one outstanding-request flag, a stale flag, and the
  // buffered instructions as a queue.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic [31:0] m_pc;
  logic [31:0] m_fpc;
  bit          m_out;
  bit          m_stale;
  ent_t        m_q[$];
  ent_t        popped[$];
  logic [31:0] m_fetched;
  logic [31:0] m_stall;

  // Memory environment.
  bit          mem_pending;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          ready_mode = 1;  // 0: low, 1: high, 2: random
  int          idr_mode = 1;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return a * 32'h9E37_79B1 + 32'h0000_5A5B;
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(3) != 0);
  endfunction

  task automatic check_outputs();
    bit ev;
    ev = !m_out && (m_q.size() < 2);
    chk("req_valid", 32'(imem_req_valid), 32'(ev));
    if (ev) chk("req_addr", imem_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("id_instr", id_instr, m_q[0].instr);
      chk("id_pc", id_pc, m_q[0].pc);
      chk("id_pc_plus4", id_pc_plus4, m_q[0].pc + 32'd4);
      chk("id_opcode", 32'(id_opcode), 32'(m_q[0].instr[6:0]));
      chk("id_funct3", 32'(id_funct3), 32'(m_q[0].instr[14:12]));
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stall", perf_stall, m_stall);
`endif
  endtask

  task automatic model_step();
    bit   hs;
    bit   pop;
    ent_t e;
    hs  = !m_out && (m_q.size() < 2) && imem_req_ready;
    pop = (m_q.size() != 0) && id_ready;
    if (id_ready && m_q.size() == 0) m_stall = m_stall + 32'd1;
    if (redirect_valid) begin
      m_q.delete();
      if (hs) begin
        m_out   = 1'b1;
        m_stale = 1'b1;
      end else if (m_out) begin
        if (imem_rsp_valid) begin
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pop) popped.push_back(m_q.pop_front());
      if (m_out && imem_rsp_valid) begin
        if (!m_stale) begin
          e.instr = imem_rsp_data;
          e.pc    = m_fpc;
          m_q.push_back(e);
          m_fetched = m_fetched + 32'd1;
        end
        m_out   = 1'b0;
        m_stale = 1'b0;
      end
      if (hs) begin
        m_out   = 1'b1;
        m_stale = 1'b0;
        m_fpc   = m_pc;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic tick(input bit rd, input logic [31:0] tgt);
    bit          hs_env;
    logic [31:0] a_env;
    check_outputs();
    redirect_valid = rd;
    redirect_pc    = tgt;
    imem_req_ready = pick(ready_mode);
    id_ready       = pick(idr_mode);
    #1;
    hs_env = imem_req_valid && imem_req_ready;
    a_env  = imem_addr;
    model_step();
    @(negedge clk);
    redirect_valid = 1'b0;
    if (hs_env) begin
      mem_pending = 1'b1;
      mem_addr    = a_env;
      mem_cnt     = $urandom_range(lat_hi, lat_lo);
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_pending) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(mem_addr);
        mem_pending    = 1'b0;
      end
    end
  endtask

  // Asynchronous reset raised mid-cycle; a response with no matching request is
  // presented on the first edge after release.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'h4);
    chk("rst_opcode", 32'(id_opcode), 32'h0);
    chk("rst_funct3", 32'(id_funct3), 32'h0);
    repeat (2) @(negedge clk);
    m_pc      = 32'h0;
    m_fpc     = 32'h0;
    m_out     = 1'b0;
    m_stale   = 1'b0;
    m_fetched = '0;
    m_stall   = '0;
    m_q.delete();
    popped.delete();
    mem_pending    = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    rst = 1'b0;
    #1;
  endtask

  int n;
  int idx;
  int npop;

  initial begin
    // Zero-wait memory from reset.
    do_reset();
    ready_mode = 1; idr_mode = 1; lat_lo = 1; lat_hi = 1;
    chk("first_req_valid", 32'(imem_req_valid), 32'h1);
    chk("first_req_addr", imem_addr, 32'h0);
    n = 0;
    while (!id_valid && n < 10) begin tick(1'b0, 32'h0); n++; end
    chk("first_id_valid", 32'(id_valid), 32'h1);
    chk("first_id_instr", id_instr, 32'h0000_0013);
    chk("first_opcode", 32'(id_opcode), 32'h13);
    chk("first_funct3", 32'(id_funct3), 32'h0);
    chk("first_pc_plus4", id_pc_plus4, 32'h4);
    repeat (8) tick(1'b0, 32'h0);
    chk("p1_pop_count", 32'(popped.size() >= 3), 32'h1);
    if (popped.size() >= 3) begin
      chk("p1_pc0", popped[0].pc, 32'h0);
      chk("p1_pc1", popped[1].pc, 32'h4);
      chk("p1_pc2", popped[2].pc, 32'h8);
      chk("p1_instr0", popped[0].instr, 32'h0000_0013);
    end

    // Decode stalled: buffer fills to exactly two, requests stop.
    idr_mode = 0;
    repeat (10) tick(1'b0, 32'h0);
    chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
    chk("stall_id_valid", 32'(id_valid), 32'h1);
    chk("stall_depth", 32'(m_q.size()), 32'h2);
    npop = popped.size();
    idr_mode = 1;
    repeat (8) tick(1'b0, 32'h0);
    chk("drain_pops", 32'(popped.size() >= npop + 2), 32'h1);
    for (int i = 1; i < popped.size(); i++) chk("seq_pc", popped[i].pc, popped[i-1].pc + 32'd4);

    // Reset in mid-flight, then hold the request at 0x8 for three cycles.
    do_reset();
    n = 0;
    while (!(m_pc == 32'h8 && !m_out) && n < 20) begin tick(1'b0, 32'h0); n++; end
    ready_mode = 0;
    repeat (3) begin
      chk("hold_valid", 32'(imem_req_valid), 32'h1);
      chk("hold_addr", imem_addr, 32'h8);
      tick(1'b0, 32'h0);
    end
    ready_mode = 1;

    // Redirect while waiting on a slow response.
    lat_lo = 4; lat_hi = 4;
    n = 0;
    while (!(m_out && !m_stale && !imem_rsp_valid) && n < 20) begin tick(1'b0, 32'h0); n++; end
    tick(1'b1, 32'h0000_0103);
    chk("redir_id_valid", 32'(id_valid), 32'h0);
    lat_lo = 1; lat_hi = 1;
    n = 0;
    while (!imem_req_valid && n < 10) begin tick(1'b0, 32'h0); n++; end
    chk("redir_addr", imem_addr, 32'h100);
    n = 0;
    while (!id_valid && n < 10) begin tick(1'b0, 32'h0); n++; end
    chk("redir_id_pc", id_pc, 32'h100);

    // Redirect coinciding with a response and a pop.
    idr_mode = 0; lat_lo = 1; lat_hi = 2;
    n = 0;
    while (!(imem_rsp_valid && m_out && !m_stale && m_q.size() >= 1) && n < 40) begin
      tick(1'b0, 32'h0);
      n++;
    end
    idr_mode = 1;
    tick(1'b1, 32'h0000_0200);
    chk("coinc_id_valid", 32'(id_valid), 32'h0);
    chk("coinc_req_valid", 32'(imem_req_valid), 32'h1);
    chk("coinc_addr", imem_addr, 32'h200);

    // PC wrap at the top of the address space.
    lat_lo = 1; lat_hi = 1;
    popped.delete();
    tick(1'b1, 32'hFFFF_FFFF);
    n = 0;
    while (!(id_valid && id_pc == 32'hFFFF_FFFC) && n < 20) begin tick(1'b0, 32'h0); n++; end
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", id_pc_plus4, 32'h0);
    repeat (6) tick(1'b0, 32'h0);
    idx = -1;
    for (int i = 0; i < popped.size(); i++) if (popped[i].pc == 32'hFFFF_FFFC) idx = i;
    chk("wrap_found", 32'(idx >= 0 && idx + 1 < popped.size()), 32'h1);
    if (idx >= 0 && idx + 1 < popped.size()) chk("wrap_next_pc", popped[idx+1].pc, 32'h0);

    // Randomised traffic.
    ready_mode = 2; idr_mode = 2; lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(31) == 0) begin
        if ($urandom_range(3) == 0) tick(1'b1, 32'hFFFF_FFF0 | 32'($urandom_range(15)));
        else tick(1'b1, $urandom);
      end else begin
        tick(1'b0, 32'h0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the RV32I core. It owns the program counter, issues word reads to instruction memory over a valid/ready request and valid response interface, and buffers returned words in a 2-entry FIFO. It presents each instruction to the decode stage with its PC, and pre-extracts `opcode`/`funct3` for the main decoder. Branch and jump redirects from execute flush the buffer and discard in-flight data.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `FIFO_DEPTH`, default `2`: instruction buffer entries. Only the value 2 is supported.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_addr` out 32: word address (bits [1:0] always 0).
- `imem_rsp_valid` in 1: read data valid. Responses arrive in order, at least 1 cycle after acceptance.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: control-flow redirect from execute.
- `redirect_pc` in 32: redirect target. Bits [1:0] are ignored (forced to 0).
- `id_valid` out 1: FIFO head valid.
- `id_ready` in 1: decode consumes the head.
- `id_instr` out 32: head instruction.
- `id_pc` out 32: head PC.
- `id_pc_plus4` out 32: `id_pc + 4`, modulo 2^32.
- `id_opcode` out 7: `id_instr[6:0]`.
- `id_funct3` out 3: `id_instr[14:12]`.

## Operation
- At most one request outstanding.
- Issue condition: FIFO occupancy + in-flight count < 2.
- FSM states:
  - REQ: `imem_req_valid` = issue condition; `imem_addr` = `pc`. On handshake, `pc` ← `pc + 4` and go to WAIT.
  - WAIT: on `imem_rsp_valid`, push {data, fetched pc} into the FIFO and go to REQ.
  - DRAIN: the outstanding response is stale. On `imem_rsp_valid`, drop it and go to REQ.
- The request address is held stable until accepted. The only exception is a redirect, which may change it.
- Redirect has highest priority in its cycle:
  - FIFO emptied; any same-cycle pop or push is ignored.
  - `pc` ← `{redirect_pc[31:2],2'b00}`.
  - Next state:
    - From WAIT: DRAIN.
    - From REQ with a same-cycle handshake: DRAIN.
    - From REQ otherwise: REQ.
    - From DRAIN: DRAIN.
  - A response in the redirect cycle is dropped. If it was the one awaited (from WAIT or DRAIN), go to REQ.
- FIFO:
  - Pop on `id_valid & id_ready`.
  - Simultaneous push and pop is allowed at any occupancy. When full, a push only arrives with a pop, because of the issue rule.
- PC arithmetic is 32-bit wrapping. `32'hFFFF_FFFC` + 4 → `32'h0000_0000`.

## Timing
- Reset values:
  - `pc` = `RESET_PC`; FSM = REQ; FIFO empty.
  - `imem_req_valid` = 0; `imem_addr` = `RESET_PC`.
  - `id_valid` = 0; `id_instr`, `id_pc`, `id_opcode`, `id_funct3` = 0; `id_pc_plus4` = 4.
- First cycle after reset deassertion: `imem_req_valid` = 1.
- Response at edge N → `id_valid` = 1 from cycle N+1 (registered FIFO). There is no combinational path from `imem_rsp_*` to `id_*`.
- With zero-wait memory (ready=1, response the cycle after acceptance), steady-state throughput is 1 instruction per 2 cycles.
- Redirect at edge N:
  - `id_valid` = 0 from N+1.
  - If the FSM is in REQ at N+1, `imem_req_valid` = 1 with the new address.
- Reset asserted mid-transaction: state is cleared immediately. Any response arriving after reset release without a matching request is ignored (the FSM is in REQ).
- `id_*` outputs are all registered.

## Configuration
- `FETCH_PERF_CNT_EN`:
  - Defined: adds outputs `perf_fetched` (32, count of FIFO pushes) and `perf_stall` (32, cycles with `id_ready & !id_valid`). Both reset to 0 and wrap.
  - Undefined: these ports and counters do not exist.

## Test plan
- Reset release with ready=1 and 1-cycle response latency, `id_ready`=1 → addresses 0x0, 0x4, 0x8 fetched; `id_pc` sequence 0x0, 0x4, 0x8; `id_opcode` matches the data (e.g. 0x00000013 → 7'b0010011, funct3 000).
- `id_ready`=0 for 10 cycles → exactly 2 entries buffered and `imem_req_valid` held 0. Then `id_ready`=1 → entries returned in order with no loss.
- `imem_req_ready`=0 for 3 cycles → `imem_addr` stable at 0x8 throughout.
- Redirect to 0x103 in WAIT → `id_valid`=0 next cycle, the late response is discarded, and the next request address is 0x100.
- Redirect in the same cycle as a response and a pop → FIFO empty, response dropped, next request at the target.
- PC = 0xFFFFFFFC → `id_pc_plus4`=0, and the next fetch is at 0x0.
